// File: rtl/systolic_feeder.sv
// systolic_feeder: skewed weight/activation sequencer for a 4x4 systolic array (FEEDER_ZERO_GATE_EN zeroes data on bubbles)
module systolic_feeder #(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_start_in,
  input  logic                cmd_load_w_in,
  input  logic                w_valid_in,
  output logic                w_ready_out,
  input  logic [4*DATA_W-1:0] w_row_in,
  input  logic                a_valid_in,
  output logic                a_ready_out,
  input  logic [4*DATA_W-1:0] a_vec_in,
  input  logic                a_last_in,
  output logic [DATA_W-1:0]   sys_data_in_11,
  output logic [DATA_W-1:0]   sys_data_in_21,
  output logic [DATA_W-1:0]   sys_data_in_31,
  output logic [DATA_W-1:0]   sys_data_in_41,
  output logic                sys_start_1,
  output logic                sys_start_2,
  output logic                sys_start_3,
  output logic                sys_start_4,
  output logic [DATA_W-1:0]   sys_weight_in_11,
  output logic [DATA_W-1:0]   sys_weight_in_12,
  output logic [DATA_W-1:0]   sys_weight_in_13,
  output logic [DATA_W-1:0]   sys_weight_in_14,
  output logic                sys_accept_w_1,
  output logic                sys_accept_w_2,
  output logic                sys_accept_w_3,
  output logic                sys_accept_w_4,
  output logic                sys_switch_in,
  output logic                busy_out,
  output logic                done_out
);
  typedef enum logic [2:0] {IDLE, LOAD_W, SWITCH, STREAM, DRAIN} state_t;
  state_t state, state_n;
  logic [1:0] cnt;
  logic w_acc, a_acc;
  logic [3:0] row_s;
  logic [DATA_W-1:0] row_d [0:3];
  assign w_ready_out = state == LOAD_W;
  assign a_ready_out = state == STREAM;
  assign busy_out = state != IDLE;
  assign w_acc = w_valid_in & w_ready_out;
  assign a_acc = a_valid_in & a_ready_out;
  // next-state: load rows, pulse switch, stream vectors, drain the skew pipe
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (cmd_start_in) state_n = cmd_load_w_in ? LOAD_W : STREAM;
      LOAD_W:  if (w_acc && cnt == 2'd3) state_n = SWITCH;
      SWITCH:  state_n = STREAM;
      STREAM:  if (a_acc && a_last_in) state_n = DRAIN;
      DRAIN:   if (cnt == 2'd3) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state register; cnt counts weight rows in LOAD_W and bubble cycles in DRAIN
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= (state == IDLE || state == STREAM) ? 2'd0 : (w_acc || state == DRAIN) ? cnt + 2'd1 : cnt;
    end
  end
  // top-edge weights, shift enables, switch pulse and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      sys_weight_in_11 <= '0;
      sys_weight_in_12 <= '0;
      sys_weight_in_13 <= '0;
      sys_weight_in_14 <= '0;
      {sys_accept_w_1, sys_accept_w_2, sys_accept_w_3, sys_accept_w_4} <= '0;
      sys_switch_in <= 1'b0;
      done_out <= 1'b0;
    end else begin
      sys_weight_in_11 <= w_acc ? w_row_in[0*DATA_W +: DATA_W] : '0;
      sys_weight_in_12 <= w_acc ? w_row_in[1*DATA_W +: DATA_W] : '0;
      sys_weight_in_13 <= w_acc ? w_row_in[2*DATA_W +: DATA_W] : '0;
      sys_weight_in_14 <= w_acc ? w_row_in[3*DATA_W +: DATA_W] : '0;
      {sys_accept_w_1, sys_accept_w_2, sys_accept_w_3, sys_accept_w_4} <= {4{w_acc}};
      sys_switch_in <= state == SWITCH;
      done_out <= state == DRAIN && cnt == 2'd3;
    end
  end
  for (genvar r = 0; r < 4; r++) begin : g_row
    logic [r:0] ps, si;
    logic [DATA_W-1:0] pd [0:r];
    logic [DATA_W-1:0] di [0:r];
    // stage inputs: stage 0 takes the accepted element, later stages the previous stage
    always_comb begin
      si[0] = a_acc;
      di[0] = a_vec_in[r*DATA_W +: DATA_W];
      for (int k = 1; k <= r; k++) begin
        si[k] = ps[k-1];
        di[k] = pd[k-1];
      end
    end
    // row skew pipe: r+1 stages, each element travelling with its own start bit
    always_ff @(posedge clk) begin
      if (rst) begin
        ps <= '0;
        for (int k = 0; k <= r; k++) pd[k] <= '0;
      end else begin
        ps <= si;
        for (int k = 0; k <= r; k++) begin
`ifdef FEEDER_ZERO_GATE_EN
          pd[k] <= si[k] ? di[k] : '0;
`else
          if (si[k]) pd[k] <= di[k];
`endif
        end
      end
    end
    assign row_s[r] = ps[r];
    assign row_d[r] = pd[r];
  end
  assign {sys_start_4, sys_start_3, sys_start_2, sys_start_1} = row_s;
  assign sys_data_in_11 = row_d[0];
  assign sys_data_in_21 = row_d[1];
  assign sys_data_in_31 = row_d[2];
  assign sys_data_in_41 = row_d[3];
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed self-checking bench for systolic_feeder
module tb_systolic_feeder;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_start_in = 1'b0, cmd_load_w_in = 1'b0;
  logic w_valid_in = 1'b0, a_valid_in = 1'b0, a_last_in = 1'b0;
  logic [63:0] w_row_in = '0, a_vec_in = '0;
  logic w_ready_out, a_ready_out, busy_out, done_out, sys_switch_in;
  logic [15:0] d11, d21, d31, d41, w11, w12, w13, w14;
  logic s1, s2, s3, s4, aw1, aw2, aw3, aw4;
  logic [63:0] dat, wts;
  logic [3:0] st, acc;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  systolic_feeder #(.DATA_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_start_in(cmd_start_in), .cmd_load_w_in(cmd_load_w_in),
    .w_valid_in(w_valid_in), .w_ready_out(w_ready_out), .w_row_in(w_row_in),
    .a_valid_in(a_valid_in), .a_ready_out(a_ready_out), .a_vec_in(a_vec_in), .a_last_in(a_last_in),
    .sys_data_in_11(d11), .sys_data_in_21(d21), .sys_data_in_31(d31), .sys_data_in_41(d41),
    .sys_start_1(s1), .sys_start_2(s2), .sys_start_3(s3), .sys_start_4(s4),
    .sys_weight_in_11(w11), .sys_weight_in_12(w12), .sys_weight_in_13(w13), .sys_weight_in_14(w14),
    .sys_accept_w_1(aw1), .sys_accept_w_2(aw2), .sys_accept_w_3(aw3), .sys_accept_w_4(aw4),
    .sys_switch_in(sys_switch_in), .busy_out(busy_out), .done_out(done_out)
  );
  assign dat = {d41, d31, d21, d11};
  assign wts = {w14, w13, w12, w11};
  assign st = {s4, s3, s2, s1};
  assign acc = {aw4, aw3, aw2, aw1};
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_dat"}, dat, 64'h0);
    check({tag, "_st"}, st, 4'h0);
    check({tag, "_wts"}, wts, 64'h0);
    check({tag, "_acc"}, acc, 4'h0);
    check({tag, "_flags"}, {sys_switch_in, busy_out, done_out, w_ready_out, a_ready_out}, 5'b0);
  endtask
  logic [63:0] rows [4] = '{64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005,
                            64'h000C_000B_000A_0009, 64'h0010_000F_000E_000D};
  logic [15:0] sk_d [4] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
  logic bv_valid [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [63:0] bv_vec [5] = '{64'h1004_1003_1002_1001, 64'h0, 64'h0,
                              64'h2004_2003_2002_2001, 64'h3004_3003_3002_3001};
  logic [3:0] bub_st [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
                             4'b0110, 4'b1100, 4'b1000, 4'b0000};
  logic stall_v [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  int stall_r [7] = '{0, 1, 0, 0, 0, 2, 3};
  initial begin
    tick;
    tick;
    rst = 1'b0;
    check_idle("reset");
    cmd_start_in = 1'b1;
    cmd_load_w_in = 1'b1;
    tick;
    cmd_start_in = 1'b0;
    cmd_load_w_in = 1'b0;
    check("ld_state", {busy_out, w_ready_out, a_ready_out}, 3'b110);
    check("ld_noacc", acc, 4'h0);
    for (int i = 0; i < 4; i++) begin
      w_valid_in = 1'b1;
      w_row_in = rows[i];
      tick;
      check("ld_acc", acc, 4'hF);
      check("ld_row", wts, rows[i]);
      check("ld_sw", sys_switch_in, 1'b0);
    end
    w_valid_in = 1'b0;
    w_row_in = '0;
    check("ld_wrdy_off", w_ready_out, 1'b0);
    tick;
    check("sw_on", sys_switch_in, 1'b1);
    check("sw_acc", acc, 4'h0);
    check("sw_wts", wts, 64'h0);
    check("sw_ardy", a_ready_out, 1'b1);
    tick;
    check("sw_off", sys_switch_in, 1'b0);
    w_valid_in = 1'b1;
    w_row_in = rows[0];
    cmd_start_in = 1'b1;
    cmd_load_w_in = 1'b1;
    tick;
    w_valid_in = 1'b0;
    cmd_start_in = 1'b0;
    cmd_load_w_in = 1'b0;
    check("ign_acc", acc, 4'h0);
    check("ign_state", {w_ready_out, a_ready_out}, 2'b01);
    a_valid_in = 1'b1;
    a_vec_in = 64'h0040_0030_0020_0010;
    a_last_in = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick;
      a_valid_in = 1'b0;
      a_last_in = 1'b0;
      check("sk_st", st, 4'b0001 << n);
      check("sk_dat", dat[n*16 +: 16], sk_d[n]);
      check("sk_ardy", a_ready_out, 1'b0);
      check("sk_done", done_out, 1'b0);
    end
    tick;
    check("sk_done_on", done_out, 1'b1);
    check("sk_idle", {busy_out, st}, 5'b0);
    tick;
    check("sk_done_off", done_out, 1'b0);
    cmd_start_in = 1'b1;
    tick;
    cmd_start_in = 1'b0;
    check("reuse_state", {a_ready_out, busy_out, w_ready_out}, 3'b110);
    check("reuse_quiet", {acc, sys_switch_in}, 5'b0);
    for (int n = 0; n < 9; n++) begin
      a_valid_in = n < 5 ? bv_valid[n] : 1'b0;
      a_vec_in = n < 5 ? bv_vec[n] : 64'h0;
      a_last_in = n == 4;
      tick;
      check("bub_st", st, bub_st[n]);
      check("bub_done", done_out, n == 8);
      check("bub_quiet", {acc, sys_switch_in}, 5'b0);
      if (n == 0) check("bub_d11_v1", d11, 16'h1001);
`ifdef FEEDER_ZERO_GATE_EN
      if (n == 1) check("bub_d11_gap", d11, 16'h0000);
      if (n == 5) check("bub_d11_drain", d11, 16'h0000);
`else
      if (n == 1) check("bub_d11_gap", d11, 16'h1001);
      if (n == 5) check("bub_d11_drain", d11, 16'h3001);
`endif
      if (n == 6) check("bub_d41_v2", d41, 16'h2004);
      if (n == 7) check("bub_d41_v3", d41, 16'h3004);
    end
    a_valid_in = 1'b0;
    a_last_in = 1'b0;
    a_vec_in = '0;
    tick;
    check("bub_done_off", {done_out, busy_out}, 2'b00);
    cmd_start_in = 1'b1;
    cmd_load_w_in = 1'b1;
    tick;
    cmd_start_in = 1'b0;
    cmd_load_w_in = 1'b0;
    for (int n = 0; n < 7; n++) begin
      w_valid_in = stall_v[n];
      w_row_in = stall_v[n] ? rows[stall_r[n]] : 64'h0;
      tick;
      check("st_acc", acc, stall_v[n] ? 4'hF : 4'h0);
      check("st_sw", sys_switch_in, 1'b0);
      if (stall_v[n]) check("st_row", wts, rows[stall_r[n]]);
    end
    w_valid_in = 1'b0;
    w_row_in = '0;
    tick;
    check("st_sw_on", sys_switch_in, 1'b1);
    a_valid_in = 1'b1;
    a_vec_in = rows[1];
    tick;
    a_valid_in = 1'b0;
    check("mid_st", st, 4'b0001);
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    check_idle("midrst");
    for (int n = 0; n < 6; n++) begin
      tick;
      check("midrst_quiet", {done_out, busy_out, st}, 6'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
